// File: rtl/two_level_cache_ctrl.sv
// Read-path sequencer for a two-level direct-mapped, inclusive, read-only cache (L1 -> L2 -> memory).
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
module two_level_cache_ctrl #(
  parameter int TAGWID1 = 3,
  parameter int SETWID1 = 9,
  parameter int TAGWID2 = 2,
  parameter int SETWID2 = 10,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe,
  input  logic [15:0]   add,
  output logic          busy,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          hit1,
  output logic          hit2,
  output logic          mem_req,
  output logic [15:0]   mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]   l1_hits,
  output logic [15:0]   l2_hits,
  output logic [15:0]   misses
`endif
);

  localparam int NSET1 = 1 << SETWID1;
  localparam int NSET2 = 1 << SETWID2;

  typedef enum logic [2:0] {IDLE, LOOK1, LOOK2, MEM_WAIT, DONE} state_t;

  state_t state, state_next;

  logic [15:0]      areg, areg_next;
  logic [DW-1:0]    rdata_next;
  logic             hit1_next, hit2_next;
  logic             mem_req_next;
  logic [15:0]      mem_addr_next;

  logic [TAGWID1-1:0] tag1_arr [NSET1];
  logic [DW-1:0]      data1    [NSET1];
  logic [NSET1-1:0]   valid1;
  logic [TAGWID2-1:0] tag2_arr [NSET2];
  logic [DW-1:0]      data2    [NSET2];
  logic [NSET2-1:0]   valid2;

  logic [TAGWID1-1:0] tag1;
  logic [SETWID1-1:0] set1;
  logic [TAGWID2-1:0] tag2;
  logic [SETWID2-1:0] set2;

  logic          l1_we, l2_we;
  logic [DW-1:0] fill_data;

  // All lookups use the captured address, so add may change freely once accepted.
  assign tag1 = areg[15 -: TAGWID1];
  assign set1 = areg[4 +: SETWID1];
  assign tag2 = areg[15 -: TAGWID2];
  assign set2 = areg[4 +: SETWID2];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    areg_next     = areg;
    rdata_next    = rdata;
    hit1_next     = hit1;
    hit2_next     = hit2;
    mem_req_next  = mem_req;
    mem_addr_next = mem_addr;
    l1_we         = 1'b0;
    l2_we         = 1'b0;
    fill_data     = mem_rdata;
    unique case (state)
      IDLE: begin
        if (strobe) begin
          areg_next  = add;
          hit1_next  = 1'b0;
          hit2_next  = 1'b0;
          state_next = LOOK1;
        end
      end
      LOOK1: begin
        if (valid1[set1] && tag1_arr[set1] == tag1) begin
          rdata_next = data1[set1];
          hit1_next  = 1'b1;
          state_next = DONE;
        end else begin
          state_next = LOOK2;
        end
      end
      LOOK2: begin
        if (valid2[set2] && tag2_arr[set2] == tag2) begin
          rdata_next = data2[set2];
          hit2_next  = 1'b1;
          l1_we      = 1'b1;
          fill_data  = data2[set2];
          state_next = DONE;
        end else begin
          mem_req_next  = 1'b1;
          mem_addr_next = areg;
          state_next    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          l1_we        = 1'b1;
          l2_we        = 1'b1;
          fill_data    = mem_rdata;
          rdata_next   = mem_rdata;
          hit1_next    = 1'b0;
          hit2_next    = 1'b0;
          mem_req_next = 1'b0;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      areg     <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rdata    <= '0;
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      valid1   <= '0;
      valid2   <= '0;
    end else begin
      state    <= state_next;
      areg     <= areg_next;
      busy     <= (state_next != IDLE);
      ready    <= (state_next == DONE);
      rdata    <= rdata_next;
      hit1     <= hit1_next;
      hit2     <= hit2_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
      if (l1_we) valid1[set1] <= 1'b1;
      if (l2_we) valid2[set2] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits alone decide whether an entry counts.
  always_ff @(posedge clk) begin
    if (!rst && l1_we) begin
      tag1_arr[set1] <= tag1;
      data1[set1]    <= fill_data;
    end
    if (!rst && l2_we) begin
      tag2_arr[set2] <= tag2;
      data2[set2]    <= fill_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] l1_cnt, l2_cnt, miss_cnt;

  // Exactly one counter moves per ready pulse, chosen by the registered hit flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      l1_cnt   <= '0;
      l2_cnt   <= '0;
      miss_cnt <= '0;
    end else if (state == DONE) begin
      if (hit1) begin
        if (l1_cnt != 16'hFFFF) l1_cnt <= l1_cnt + 16'd1;
      end else if (hit2) begin
        if (l2_cnt != 16'hFFFF) l2_cnt <= l2_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

  assign l1_hits = l1_cnt;
  assign l2_hits = l2_cnt;
  assign misses  = miss_cnt;
`endif

endmodule

// File: tb/tb_two_level_cache_ctrl.sv
// Directed bench for two_level_cache_ctrl with a set/tag-level cache model and a per-cycle ready checker.
module tb_two_level_cache_ctrl;

  localparam int K_MEM = 0;
  localparam int K_L1  = 1;
  localparam int K_L2  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [15:0] add = '0;
  logic        busy, ready, hit1, hit2, mem_req;
  logic [7:0]  rdata;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] l1_hits, l2_hits, misses;
`endif

  two_level_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .strobe    (strobe),
    .add       (add),
    .busy      (busy),
    .ready     (ready),
    .rdata     (rdata),
    .hit1      (hit1),
    .hit2      (hit2),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .l1_hits   (l1_hits),
    .l2_hits   (l2_hits),
    .misses    (misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cache model at the level of "which set holds which tag"; the DUT's FSM is not mirrored.
  bit         m1_v [512];
  int         m1_tag [512];
  logic [7:0] m1_dat [512];
  bit         m2_v [1024];
  int         m2_tag [1024];
  logic [7:0] m2_dat [1024];

  function automatic void model_clear();
    for (int i = 0; i < 512; i++) m1_v[i] = 1'b0;
    for (int i = 0; i < 1024; i++) m2_v[i] = 1'b0;
  endfunction

  function automatic void model_access(input int a, input logic [7:0] mv,
                                       output int kind, output logic [7:0] d);
    int s1, t1, s2, t2;
    s1 = (a / 16) % 512;
    t1 = a / 8192;
    s2 = (a / 16) % 1024;
    t2 = a / 16384;
    if (m1_v[s1] && m1_tag[s1] == t1) begin
      kind = K_L1;
      d    = m1_dat[s1];
    end else if (m2_v[s2] && m2_tag[s2] == t2) begin
      kind = K_L2;
      d    = m2_dat[s2];
      m1_v[s1] = 1'b1; m1_tag[s1] = t1; m1_dat[s1] = d;
    end else begin
      kind = K_MEM;
      d    = mv;
      m1_v[s1] = 1'b1; m1_tag[s1] = t1; m1_dat[s1] = d;
      m2_v[s2] = 1'b1; m2_tag[s2] = t2; m2_dat[s2] = d;
    end
  endfunction

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  // Every ready pulse must match the oldest expectation, on the predicted cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("stray_ready", 32'(ready), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("ready_rdata", 32'(rdata), 32'(e.data));
          check("ready_hit1", 32'(hit1), 32'(e.kind == K_L1));
          check("ready_hit2", 32'(hit2), 32'(e.kind == K_L2));
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        check("ready_missing", 32'(ready), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns the cycle count seen just after the accepting edge.
  task automatic start_req(input logic [15:0] a, output int acc);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    strobe = 1'b1;
    add    = a;
    @(negedge clk);
    strobe = 1'b0;
    add    = 16'h0000;
    acc    = cyc;
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_mem_req(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (mem_req) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic read_req(input logic [15:0] a, input logic [7:0] mv, input int dly,
                          input int ek, input logic [7:0] ed, input bit hold);
    int         kind, acc, n;
    logic [7:0] d;
    bit         seen;
    exp_t       e;
    model_access(32'(a), mv, kind, d);
    check("model_kind", 32'(kind), 32'(ek));
    check("model_data", 32'(d), 32'(ed));
    start_req(a, acc);
    if (hold) begin
      strobe = 1'b1;
      add    = 16'hFFFF;
    end
    if (kind != K_MEM) begin
      e.kind = kind;
      e.data = d;
      e.cyc  = acc + ((kind == K_L1) ? 1 : 2);
      exp_q.push_back(e);
    end else begin
      wait_mem_req(seen);
      check("mem_req_seen", 32'(seen), 32'd1);
      check("mem_req_rise_cycle", 32'(cyc), 32'(acc + 2));
      check("mem_addr", 32'(mem_addr), 32'(a));
      for (int k = 1; k < dly; k++) begin
        @(negedge clk);
        check("wait_mem_req", 32'(mem_req), 32'd1);
        check("wait_busy", 32'(busy), 32'd1);
      end
      mem_ack   = 1'b1;
      mem_rdata = mv;
      e.kind = K_MEM;
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      strobe    = 1'b0;
      add       = 16'h0000;
      check("mem_req_dropped", 32'(mem_req), 32'd0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  acc;
    bit  seen;
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hit1", 32'(hit1), 32'd0);
    check("rst_hit2", 32'(hit2), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, L1 hit, eviction by 0x3234, L2 refill, L1 hit again.
    read_req(16'h1234, 8'h5A, 4, K_MEM, 8'h5A, 1'b0);
    read_req(16'h1234, 8'h00, 0, K_L1,  8'h5A, 1'b0);
    read_req(16'h3234, 8'hC3, 2, K_MEM, 8'hC3, 1'b0);
    read_req(16'h1234, 8'h00, 0, K_L2,  8'h5A, 1'b0);
    read_req(16'h1234, 8'h00, 0, K_L1,  8'h5A, 1'b0);

    // strobe held high with add=0xFFFF through a fill must not start a second request.
    read_req(16'h8000, 8'h11, 3, K_MEM, 8'h11, 1'b1);
    @(negedge clk);
    check("hold_no_second_busy", 32'(busy), 32'd0);
    check("hold_no_second_req", 32'(mem_req), 32'd0);
    check("hold_mem_addr_kept", 32'(mem_addr), 32'h8000);

`ifdef CACHE_STATS_EN
    check("stat_l1_hits", 32'(l1_hits), 32'd2);
    check("stat_l2_hits", 32'(l2_hits), 32'd1);
    check("stat_misses", 32'(misses), 32'd3);
    force dut.l1_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.l1_cnt;
    read_req(16'h1234, 8'h00, 0, K_L1, 8'h5A, 1'b0);
    @(negedge clk);
    check("stat_l1_saturated", 32'(l1_hits), 32'hFFFF);
`endif

    // 0x3234 was pushed out of L1 by the L2 refill of 0x1234 but still lives in L2.
    read_req(16'h3234, 8'h00, 0, K_L2, 8'hC3, 1'b0);
    read_req(16'hFFF0, 8'hEE, 1, K_MEM, 8'hEE, 1'b0);
    read_req(16'hFFF0, 8'h00, 0, K_L1, 8'hEE, 1'b0);

    // Reset while waiting on memory discards the request and invalidates both levels.
    start_req(16'h4444, acc);
    wait_mem_req(seen);
    check("rst_test_mem_req_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    read_req(16'h1234, 8'h77, 2, K_MEM, 8'h77, 1'b0);
    read_req(16'h1234, 8'h00, 0, K_L1, 8'h77, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
